// File: rtl/izh_neuron_sequencer_if.sv
// Sequencer bundle: step control, current lookup, integrator bus, spike stream.
// master = sequencer side, slave = surrounding environment.
interface izh_neuron_sequencer_if #(
    parameter int WIDTH = 20,
    parameter int IDX_W = 4
);
    logic                    step_start;
    logic                    busy;
    logic                    step_done;
    logic [IDX_W-1:0]        i_idx;
    logic signed [WIDTH-1:0] i_data;
    logic signed [WIDTH-1:0] int_I;
    logic signed [WIDTH-1:0] int_v_old;
    logic signed [WIDTH-1:0] int_w_old;
    logic signed [WIDTH-1:0] int_v_new;
    logic signed [WIDTH-1:0] int_w_new;
    logic                    int_fire;
    logic                    spk_valid;
    logic [IDX_W-1:0]        spk_id;
    logic                    spk_ready;

    modport master (
        input  step_start, i_data, int_v_new, int_w_new, int_fire, spk_ready,
        output busy, step_done, i_idx, int_I, int_v_old, int_w_old,
        output spk_valid, spk_id
    );

    modport slave (
        output step_start, i_data, int_v_new, int_w_new, int_fire, spk_ready,
        input  busy, step_done, i_idx, int_I, int_v_old, int_w_old,
        input  spk_valid, spk_id
    );
endinterface

// File: rtl/izh_neuron_sequencer.sv
// Time-multiplexes one combinational Izhikevich integrator over N_NEURONS,
// holding v/w per neuron and queueing fired indices in a FWFT spike FIFO.
module izh_neuron_sequencer #(
    parameter int WIDTH      = 20,
    parameter int FR_WIDTH   = 11,
    parameter int N_NEURONS  = 16,
    parameter int IDX_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rst,
    izh_neuron_sequencer_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int V_RST_I = -65 * (2 ** FR_WIDTH);
    localparam int W_RST_I = -13 * (2 ** FR_WIDTH);
    localparam logic signed [WIDTH-1:0] V_RST = WIDTH'(V_RST_I);
    localparam logic signed [WIDTH-1:0] W_RST = WIDTH'(W_RST_I);

    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic signed [WIDTH-1:0] v_mem [N_NEURONS];
    logic signed [WIDTH-1:0] w_mem [N_NEURONS];
    logic [IDX_W-1:0]        fifo  [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W:0]          count;

    logic run, full, empty, pop, push, stall, adv, last;

    // Handshake decode; a pop frees the slot a same-cycle push needs
    always_comb begin
        run   = (state == S_RUN);
        full  = (count == (PTR_W+1)'(FIFO_DEPTH));
        empty = (count == '0);
        pop   = !empty && bus.spk_ready;
        stall = run && bus.int_fire && full && !pop;
        adv   = run && !stall;
        push  = adv && bus.int_fire;
        last  = (idx == IDX_W'(N_NEURONS - 1));
    end

    // Integrator drive and status outputs, quiet outside a sweep
    always_comb begin
        bus.busy      = run;
        bus.step_done = (state == S_DONE);
        bus.i_idx     = run ? idx : '0;
        bus.int_I     = run ? bus.i_data : '0;
        bus.int_v_old = run ? v_mem[idx] : '0;
        bus.int_w_old = run ? w_mem[idx] : '0;
        bus.spk_valid = !empty;
        bus.spk_id    = empty ? '0 : fifo[rd_ptr];
    end

    // Sweep FSM: one neuron per non-stalled cycle, then a one-cycle DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (bus.step_start) state <= S_RUN;
                end
                S_RUN: begin
                    if (adv) begin
                        if (last) begin
                            state <= S_DONE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Neuron state write-back, skipped on a stalled retry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k] <= V_RST;
                w_mem[k] <= W_RST;
            end
        end else if (adv) begin
            v_mem[idx] <= bus.int_v_new;
            w_mem[idx] <= bus.int_w_new;
        end
    end

    // Spike FIFO storage; contents beyond count are never observed
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= idx;
    end

    // Spike FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_izh_neuron_sequencer.sv
// Directed bench for izh_neuron_sequencer with a reference integrator,
// shadow v/w state and a spike scoreboard queue.
module tb_izh_neuron_sequencer;
    localparam int W  = 20;
    localparam int FR = 11;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int D  = 8;

    localparam logic signed [W-1:0] V_RST = W'(-65 * (2 ** FR));
    localparam logic signed [W-1:0] W_RST = W'(-13 * (2 ** FR));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    izh_neuron_sequencer_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    izh_neuron_sequencer #(
        .WIDTH(W), .FR_WIDTH(FR), .N_NEURONS(N), .IDX_W(IW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic signed [W-1:0] cur_tab [N];
    logic                force_fire;

    // Reference Izhikevich step, dt = 1/4 ms, c = -65, d = 8
    function automatic logic [2*W:0] izh(input logic signed [W-1:0] v,
                                         input logic signed [W-1:0] w,
                                         input logic signed [W-1:0] i,
                                         input logic ff);
        longint vl, wl, il, v2, dv, dw, nv, nw;
        logic f;
        vl = v; wl = w; il = i;
        v2 = (vl * vl) >>> FR;
        dv = ((v2 * 41) >>> 10) + 5 * vl + (longint'(140) <<< FR) - wl + il;
        dw = ((((vl * 205) >>> 10) - wl) * 20) >>> 10;
        nv = vl + (dv >>> 2);
        nw = wl + (dw >>> 2);
        f  = ff || (nv >= (longint'(30) <<< FR));
        if (f) begin
            nv = -65 * (longint'(1) <<< FR);
            nw = wl + (longint'(8) <<< FR);
        end
        return {f, W'(nw), W'(nv)};
    endfunction

    logic [2*W:0] ir;
    always_comb bus.i_data = cur_tab[bus.i_idx];
    always_comb begin
        ir = izh(bus.int_v_old, bus.int_w_old, bus.int_I, force_fire);
        bus.int_v_new = ir[W-1:0];
        bus.int_w_new = ir[2*W-1:W];
        bus.int_fire  = ir[2*W];
    end

    int checks = 0;
    int errors = 0;

    int m_state, m_idx, cyc, done_cnt, done_cyc, nfires, obs_stall;
    logic signed [W-1:0] sv [N];
    logic signed [W-1:0] sw [N];
    logic signed [W-1:0] w3_exp;
    int expq [$];
    int popped [$];
    logic prev_busy;
    logic [IW-1:0] prev_idx;
    bit chk_v3, chk_rst;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_idx   = 0;
        expq.delete();
        for (int k = 0; k < N; k++) begin
            sv[k] = V_RST;
            sw[k] = W_RST;
        end
    endtask

    // One clock: check outputs against model, then advance the model
    task automatic tick();
        logic [2*W:0] r;
        logic f, pop, stall;
        int occ;
        #1;
        chk("busy", bus.busy, (m_state == 1));
        chk("step_done", bus.step_done, (m_state == 2));
        chk("spk_valid", bus.spk_valid, (expq.size() != 0));
        if (expq.size() != 0) chk("spk_id", bus.spk_id, expq[0]);
        else chk("spk_id_idle", bus.spk_id, 0);
        if (m_state == 1) begin
            chk("i_idx", bus.i_idx, m_idx);
            chk("int_I", bus.int_I, cur_tab[m_idx]);
            chk("v_old", bus.int_v_old, sv[m_idx]);
            chk("w_old", bus.int_w_old, sw[m_idx]);
            if (chk_v3 && m_idx == 3) begin
                chk("t2_v3_reset", bus.int_v_old, V_RST);
                chk("t2_w3_plus8", bus.int_w_old, w3_exp);
            end
            if (chk_rst) begin
                chk("t6_v_rst", bus.int_v_old, V_RST);
                chk("t6_w_rst", bus.int_w_old, W_RST);
            end
        end else begin
            chk("i_idx_idle", bus.i_idx, 0);
            chk("v_old_idle", bus.int_v_old, 0);
        end
        if (bus.step_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.spk_valid && bus.spk_ready) popped.push_back(int'(bus.spk_id));
        if (bus.busy && prev_busy && bus.i_idx == prev_idx) obs_stall++;
        prev_busy = bus.busy;
        prev_idx  = bus.i_idx;

        occ = expq.size();
        pop = (occ != 0) && bus.spk_ready;
        if (rst) begin
            model_reset();
        end else if (m_state == 1) begin
            r = izh(sv[m_idx], sw[m_idx], cur_tab[m_idx], force_fire);
            f = r[2*W];
            stall = f && (occ == D) && !pop;
            if (pop) void'(expq.pop_front());
            if (!stall) begin
                if (f) begin
                    expq.push_back(m_idx);
                    nfires++;
                    if (m_idx == 3) w3_exp = sw[3] + W'(8 * (2 ** FR));
                end
                sv[m_idx] = r[W-1:0];
                sw[m_idx] = r[2*W-1:W];
                if (m_idx == N - 1) begin
                    m_state = 2;
                    m_idx   = 0;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            if (pop) void'(expq.pop_front());
            if (m_state == 2) m_state = 0;
            else if (bus.step_start) begin
                m_state = 1;
                m_idx   = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_step();
        int n;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        n = 0;
        while (m_state != 0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0;
        rst = 1'b1;
        bus.step_start = 1'b0;
        bus.spk_ready  = 1'b0;
        force_fire = 1'b0;
        chk_v3 = 0; chk_rst = 0;
        prev_busy = 1'b0; prev_idx = '0;
        done_cnt = 0; done_cyc = -1; nfires = 0; obs_stall = 0; cyc = 0;
        w3_exp = '0;
        for (int k = 0; k < N; k++) cur_tab[k] = '0;
        model_reset();
        @(negedge clk);

        // 1: reset state, then one quiet sweep
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_spk_valid", bus.spk_valid, 0);
        chk("rst_spk_id", bus.spk_id, 0);
        chk("rst_step_done", bus.step_done, 0);
        cyc = 0; done_cnt = 0; popped.delete();
        run_step();
        chk("t1_done_cycle", done_cyc, N + 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_no_spikes", popped.size(), 0);

        // 2: current into neuron 3 only, repeated sweeps until it fires
        cur_tab[3] = W'(20 * (2 ** FR));
        bus.spk_ready = 1'b1;
        popped.delete(); nfires = 0;
        for (int s = 0; s < 60 && nfires == 0; s++) run_step();
        chk("t2_fired", (nfires > 0), 1);
        chk_v3 = 1;
        run_step();
        chk_v3 = 0;
        repeat (3) tick();
        chk("t2_popped_any", (popped.size() > 0), 1);
        foreach (popped[k]) chk("t2_id", popped[k], 3);
        cur_tab[3] = '0;

        // 3/4: everyone fires with the consumer stalled, then drain
        force_fire = 1'b1;
        bus.spk_ready = 1'b0;
        popped.delete(); done_cnt = 0; obs_stall = 0;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        repeat (14) tick();
        #1;
        chk("t3_stall_idx", bus.i_idx, 8);
        chk("t3_busy", bus.busy, 1);
        chk("t3_full_valid", bus.spk_valid, 1);
        chk("t3_stalled", (obs_stall > 0), 1);
        bus.spk_ready = 1'b1;
        tick();
        base = obs_stall;
        for (int n = 0; n < 80 && !(m_state == 0 && expq.size() == 0); n++)
            tick();
        chk("t4_no_stall", obs_stall - base, 0);
        chk("t3_pop_count", popped.size(), N);
        foreach (popped[k]) chk("t3_order", popped[k], k);
        chk("t3_done_cnt", done_cnt, 1);
        force_fire = 1'b0;

        // 5: second step_start while busy is ignored
        done_cnt = 0; done_cyc = -1;
        bus.step_start = 1'b1;
        cyc = 0;
        tick();
        bus.step_start = 1'b0;
        repeat (4) tick();
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        repeat (22) tick();
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_done_cycle", done_cyc, N + 1);

        // 6: reset in the middle of a sweep with spikes queued
        for (int k = 0; k < N; k++) cur_tab[k] = W'(5 * (2 ** FR));
        run_step();
        for (int k = 0; k < N; k++) cur_tab[k] = '0;
        force_fire = 1'b1;
        bus.spk_ready = 1'b0;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        repeat (7) tick();
        #1;
        chk("t6_at_idx7", bus.i_idx, 7);
        chk("t6_fifo_loaded", bus.spk_valid, 1);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force_fire = 1'b0;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_spk_valid", bus.spk_valid, 0);
        chk("t6_step_done", bus.step_done, 0);
        repeat (3) tick();
        chk("t6_no_done", done_cnt - d0, 0);
        chk_rst = 1;
        run_step();
        chk_rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
